// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multu/mult (and divu when MULDIV_DIVU_EN is defined) with HI/LO registers
// A shift-add or restoring shift-subtract step runs per cycle, and HI/LO load only when the result is final.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  input  logic [1:0]       sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] dout
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, state_next;
  logic [WIDTH-1:0] m, a_mag, b_mag;
  logic [2*WIDTH-1:0] p, p_next, res, mul_next;
  logic [WIDTH:0] sum;
  logic [CW-1:0] cnt;
  logic neg, legal, accept;
`ifdef MULDIV_DIVU_EN
  logic div;
  logic [WIDTH:0] diff;
  logic [2*WIDTH-1:0] div_next;
  assign legal = op != 2'b11;
  assign diff = p[2*WIDTH-1:WIDTH-1] - {1'b0, m};
  assign div_next = diff[WIDTH] ? {p[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
  assign p_next = div ? div_next : mul_next;
`else
  assign legal = !op[1];
  assign p_next = mul_next;
`endif
  assign accept = start && legal && state == S_IDLE;
  assign a_mag = (op == 2'b01 && a[WIDTH-1]) ? -a : a;
  assign b_mag = (op == 2'b01 && b[WIDTH-1]) ? -b : b;
  // The multiplier sits in the low half and shifts out as the partial product shifts in.
  assign sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
  assign mul_next = {sum, p[WIDTH-1:1]};
  assign res = neg ? -p : p;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else state <= state_next;
  end
  always_comb begin
    state_next = (state == S_IDLE) ? (accept ? S_RUN : S_IDLE) :
                 (state == S_RUN)  ? (cnt == '0 ? S_DONE : S_RUN) : S_IDLE;
  end
  always_comb begin
    busy = state != S_IDLE;
    done = state == S_DONE;
    dout = (sel == 2'b01) ? hi : (sel == 2'b10) ? lo : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m   <= '0;
      p   <= '0;
      cnt <= '0;
      neg <= 1'b0;
      hi  <= '0;
      lo  <= '0;
`ifdef MULDIV_DIVU_EN
      div <= 1'b0;
`endif
    end else begin
      if (accept) begin
        m   <= op[1] ? b : a_mag;
        p   <= {{WIDTH{1'b0}}, op[1] ? a : b_mag};
        cnt <= CW'(WIDTH);
        neg <= op == 2'b01 && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULDIV_DIVU_EN
        div <= op[1];
`endif
      end else if (state == S_RUN && cnt != '0) begin
        p   <= p_next;
        cnt <= cnt - CW'(1);
      end
      if (state == S_RUN && cnt == '0) {hi, lo} <= res;
      else if (state == S_IDLE && !accept) begin
        if (wr_hi) hi <= wdata;
        if (wr_lo) lo <= wdata;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed stimulus with a result queue checked by an independent done monitor
module tb_muldiv_unit;
  localparam int W = 32;
  logic clk = 0, rst_n = 0, start = 0, wr_hi = 0, wr_lo = 0;
  logic [1:0] op = 0, sel = 0;
  logic [W-1:0] a = 0, b = 0, wdata = 0;
  logic busy, done;
  logic [W-1:0] hi, lo, dout;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {logic [W-1:0] h; logic [W-1:0] l; int c;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata), .sel(sel),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dout(dout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string n, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no pulse at cycle %0d", cyc);
      end else begin
        mon_e = q.pop_front();
        chk("res_hi", hi, mon_e.h);
        chk("res_lo", lo, mon_e.l);
        chk("latency", W'(cyc), W'(mon_e.c));
      end
    end
  end
  task automatic issue(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y, logic [W-1:0] eh, logic [W-1:0] el);
    op = o;
    a = x;
    b = y;
    start = 1;
    q.push_back('{eh, el, cyc + 34});
  endtask
  task automatic wait_idle(string n);
    int k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(n, W'(busy), 0);
  endtask
  task automatic run(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y, logic [W-1:0] eh, logic [W-1:0] el);
    @(negedge clk);
    issue(o, x, y, eh, el);
    @(negedge clk);
    start = 0;
    chk("accept_busy", W'(busy), 1);
    wait_idle("run_timeout");
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", W'(busy), 0);
    chk("rst_done", W'(done), 0);
    wr_hi = 1; wdata = 32'h12345678;
    @(negedge clk);
    wr_hi = 0;
    chk("mthi", hi, 32'h12345678);
    wr_lo = 1; wdata = 32'hCAFEBABE;
    @(negedge clk);
    wr_lo = 0;
    chk("mtlo", lo, 32'hCAFEBABE);
    chk("mtlo_hi_kept", hi, 32'h12345678);
    sel = 2'b10; #1 chk("dout_lo", dout, 32'hCAFEBABE);
    sel = 2'b01; #1 chk("dout_hi", dout, 32'h12345678);
    sel = 2'b00; #1 chk("dout_sel00", dout, 0);
    sel = 2'b11; #1 chk("dout_sel11", dout, 0);
    @(negedge clk);
    wr_hi = 1; wr_lo = 1; wdata = 32'h55AA55AA;
    @(negedge clk);
    wr_hi = 0; wr_lo = 0;
    chk("mthilo_hi", hi, 32'h55AA55AA);
    chk("mthilo_lo", lo, 32'h55AA55AA);
    op = 0; a = '1; b = '1; start = 1;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_busy", W'(busy), 0);
    chk("midrst_done", W'(done), 0);
    sel = 2'b01; #1 chk("midrst_dout", dout, 0);
    repeat (40) @(negedge clk);
    chk("midrst_idle", W'(busy), 0);
    run(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    sel = 2'b10; #1 chk("multu_dout", dout, 32'h00000001);
    run(2'b01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run(2'b01, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run(2'b01, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h0, 32'd30);
    run(2'b00, 32'h00010000, 32'h00010000, 32'h1, 32'h0);
    @(negedge clk);
    issue(2'b00, 32'd1234, 32'd5678, 32'h0, 32'd7006652);
    begin
      int k = 0;
      do begin
        @(negedge clk);
        a = k + 11;
        b = k + 3;
        start = 1;
        k++;
      end while (!done && k < 100);
      chk("hs_done_seen", W'(done), 1);
    end
    @(negedge clk);
    issue(2'b00, 32'd6, 32'd7, 32'h0, 32'd42);
    @(negedge clk);
    start = 0;
    chk("hs_restart", W'(busy), 1);
    wait_idle("hs_timeout");
    @(negedge clk);
    issue(2'b00, 32'd2, 32'd3, 32'h0, 32'd6);
    wr_lo = 1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    start = 0; wr_lo = 0;
    chk("startwr_busy", W'(busy), 1);
    chk("startwr_lo", lo, 32'd42);
    wait_idle("startwr_timeout");
    @(negedge clk);
    issue(2'b00, 32'd3, 32'd3, 32'h0, 32'd9);
    @(negedge clk);
    start = 0; wr_lo = 1; wr_hi = 1; wdata = 32'h0000BEEF;
    repeat (3) @(negedge clk);
    chk("busywr_lo", lo, 32'd6);
    chk("busywr_hi", hi, 32'd0);
    wr_lo = 0; wr_hi = 0;
    wait_idle("busywr_timeout");
`ifdef MULDIV_DIVU_EN
    run(2'b10, 32'd100, 32'd7, 32'd2, 32'd14);
    run(2'b10, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
    run(2'b10, 32'hFFFFFFFF, 32'd10, 32'd5, 32'h19999999);
`else
    @(negedge clk);
    op = 2'b10; a = 32'd100; b = 32'd7; start = 1;
    @(negedge clk);
    start = 0;
    chk("divu_off_busy", W'(busy), 0);
    chk("divu_off_hi", hi, 0);
    chk("divu_off_lo", lo, 32'd9);
`endif
    @(negedge clk);
    op = 2'b11; a = 32'd5; b = 32'd5; start = 1;
    @(negedge clk);
    start = 0;
    chk("op11_busy", W'(busy), 0);
    repeat (40) @(negedge clk);
    chk("queue_empty", W'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers. It is the sequential successor to the single-cycle Multu/sel decode path: it is width-parametrised, adds signed multiply, optional unsigned divide, mthi/mtlo writes and a busy/done handshake. It sits beside the ALU in the datapath. Control asserts start with an op code, stalls on busy, and reads HI/LO through sel for mfhi/mflo.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
start  in  1  request a new operation; accepted only when busy=0
op  in  2  00 multu, 01 mult (signed), 10 divu (only with MULDIV_DIVU_EN), 11 reserved
a  in  WIDTH  operand A (multiplicand / dividend)
b  in  WIDTH  operand B (multiplier / divisor)
wr_hi  in  1  mthi: write wdata into HI
wr_lo  in  1  mtlo: write wdata into LO
wdata  in  WIDTH  data for wr_hi/wr_lo
sel  in  2  01 select HI, 10 select LO, others select zero
busy  out  1  high while an operation is in progress
done  out  1  one-cycle pulse; HI/LO hold the new result in this cycle
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
dout  out  WIDTH  combinational mux of hi/lo per sel (mfhi/mflo readout)

Behaviour:
- Reset: sampled on the clk edge when rst_n=0. Sets state IDLE, busy=0, done=0, hi=0, lo=0, and clears all internal registers. Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE -> RUN: on start=1 with a legal op. a and b are latched, the iteration counter is loaded with WIDTH, and busy=1 from the next cycle. An illegal op (11, or 10 without the macro) is ignored and the state stays IDLE.
- RUN: performs exactly one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle for WIDTH cycles, then moves to DONE.
- DONE: busy=1 and done=1 for one cycle. hi/lo are updated on the edge entering DONE. The state returns to IDLE next cycle, where busy=0.
- Latency: start accepted at edge N gives done=1 in the cycle after edge N+WIDTH+1. A new start is accepted in the cycle after done.
- multu: {hi,lo} = a*b as an unsigned 2*WIDTH product.
- mult: operands are converted to magnitudes, multiplied unsigned, and the 2*WIDTH result is negated if the signs differ. Example: -1 * 1 gives hi=all ones, lo=all ones.
- divu: lo = a/b, hi = a%b. Divide by zero uses full latency, gives lo = all ones and hi = a, and raises no error.
- start while busy: ignored; the operation in flight is unaffected.
- wr_hi/wr_lo: take effect on the next edge only when busy=0 and the unit is not accepting a start.
  - start with a legal op takes priority over a write in the same cycle; the write is dropped.
  - wr_hi and wr_lo together update both registers.
  - While busy, writes are dropped.
- dout/hi/lo: hold the previous values throughout RUN; there are no partial results visible. sel=00 or 11 gives dout=0.
- All arithmetic wraps modulo 2^(2*WIDTH); there is no overflow flag.

Optional Feature:
MULDIV_DIVU_EN:
- Defined: op=10 performs unsigned divide as above.
- Undefined: the divide datapath is not built, op=10 is treated as illegal (start ignored, busy stays 0), and the area is multiply-only.

Test Plan:
- Reset: rst_n=0 for 2 cycles after random ops -> hi=0, lo=0, busy=0, done=0; then sel=01 -> dout=0.
- multu, WIDTH=32: a=0xFFFFFFFF, b=0xFFFFFFFF, start -> done exactly 33 cycles after accept edge; hi=0xFFFFFFFE, lo=0x00000001; sel=10 -> dout=0x00000001.
- mult: a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- Handshake: start asserted again every cycle during busy with different operands -> only the first operation executes, one done pulse, result matches the first operands; start in the cycle after done is accepted.
- mthi/mtlo: wr_hi=1, wdata=0x12345678 while idle -> hi=0x12345678. wr_lo during busy -> lo unchanged. start and wr_lo in the same idle cycle -> write dropped, operation runs.
- divu (macro on): a=100, b=7 -> lo=14, hi=2. b=0 -> lo=0xFFFFFFFF, hi=100. Macro off: op=10 start -> busy stays 0 and hi/lo unchanged. Reset asserted mid-RUN -> no done pulse, hi=lo=0.
